// File: rtl/sdram_master_defs.sv
// Shared definitions for the SDRAM word master.
//   DEF_BYTES   : default bytes per CPU word
//   DEF_LANE_W  : lane-index width for the default word size
//   state_t     : 2-bit FSM state encoding
//   lane_lsb()  : bit offset of byte lane k inside a word
package sdram_master_defs;

  localparam int unsigned DEF_BYTES  = 4;
  localparam int unsigned DEF_LANE_W = (DEF_BYTES > 1) ? $clog2(DEF_BYTES) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_t;

  function automatic int unsigned lane_lsb(input int unsigned k);
    return 8 * k;
  endfunction

endpackage

// File: rtl/sdram_lane_sel.sv
// Priority finder: lowest enabled byte lane strictly above a given index.
//   i_be    : byte enables
//   i_from  : current lane index
//   i_start : 1 = search from "-1" (every enabled lane qualifies)
//   o_lane  : lowest qualifying lane (0 when none)
//   o_none  : no enabled lane remains
module sdram_lane_sel
  import sdram_master_defs::*;
#(
  parameter int unsigned BYTES = DEF_BYTES,
  parameter int unsigned LW    = DEF_LANE_W
) (
  input  logic [BYTES-1:0] i_be,
  input  logic [LW-1:0]    i_from,
  input  logic             i_start,
  output logic [LW-1:0]    o_lane,
  output logic             o_none
);

  always_comb begin
    o_lane = '0;
    o_none = 1'b1;
    // Scan downwards so the last hit is the lowest qualifying lane.
    for (int i = int'(BYTES) - 1; i >= 0; i--) begin
      if (i_be[i] && (i_start || (i > int'(i_from)))) begin
        o_lane = LW'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_word_master.sv
// SDRAM word master: splits 32-bit CPU word accesses into sequential
// single-byte requests (little-endian, enabled lanes only) toward a
// byte-wide SDRAM controller and reassembles read data.
//   i_cpu_*  : CPU request side (req sampled only when idle)
//   o_cpu_*  : busy, assembled read data, one-cycle done pulse, timeout err
//   o_mem_*  : one-cycle byte request, write enable, address, write byte
//   i_mem_*  : byte completion and read byte from the controller
module sdram_word_master
  import sdram_master_defs::*;
#(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned BYTES   = DEF_BYTES,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cpu_req,
  input  logic                 i_cpu_wren,
  input  logic [ADDR_W-1:0]    i_cpu_addr,
  input  logic [8*BYTES-1:0]   i_cpu_wdata,
  input  logic [BYTES-1:0]     i_cpu_be,
  output logic                 o_cpu_busy,
  output logic [8*BYTES-1:0]   o_cpu_rdata,
  output logic                 o_cpu_done,
  output logic                 o_cpu_err,
  output logic                 o_mem_request,
  output logic                 o_mem_wren,
  output logic [ADDR_W-1:0]    o_mem_address,
  output logic [7:0]           o_mem_data,
  input  logic [7:0]           i_mem_data,
  input  logic                 i_mem_done
);

  localparam int unsigned LW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic                 r_wren;
  logic [ADDR_W-1:0]    r_addr;
  logic [8*BYTES-1:0]   r_wdata;
  logic [BYTES-1:0]     r_be;
  logic [8*BYTES-1:0]   r_rdata;
  logic [LW-1:0]        r_lane;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;

  state_t               w_state_nxt;
  logic [8*BYTES-1:0]   w_rdata_nxt;
  logic [LW-1:0]        w_lane_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_err_nxt;
  logic                 w_accept;

  logic [BYTES-1:0]     w_sel_be;
  logic                 w_sel_start;
  logic [LW-1:0]        w_sel_lane;
  logic                 w_sel_none;

  // In idle the finder looks at the incoming enables, otherwise at the latched ones.
  assign w_sel_start = (r_state == StIdle);
  assign w_sel_be    = w_sel_start ? i_cpu_be : r_be;
  assign w_cnt_inc   = r_cnt + CW'(1);

  sdram_lane_sel #(
    .BYTES (BYTES),
    .LW    (LW)
  ) u_lane_sel (
    .i_be    (w_sel_be),
    .i_from  (r_lane),
    .i_start (w_sel_start),
    .o_lane  (w_sel_lane),
    .o_none  (w_sel_none)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_lane_nxt  = r_lane;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cpu_req) begin
          w_accept    = 1'b1;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          if (!w_sel_none) begin
            w_state_nxt = StIssue;
            w_lane_nxt  = w_sel_lane;
          end else begin
            w_state_nxt = StDone;
          end
        end
      end
      StIssue: begin
        w_state_nxt = StWait;
        w_cnt_nxt   = '0;
      end
      StWait: begin
        if (i_mem_done) begin
          if (!r_wren) begin
            w_rdata_nxt[lane_lsb(32'(r_lane)) +: 8] = i_mem_data;
          end
          if (w_sel_none) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StIssue;
            w_lane_nxt  = w_sel_lane;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          // Abandon the remaining lanes once the controller stops answering.
          if (w_cnt_inc == CW'(TIMEOUT)) begin
            w_state_nxt = StDone;
            w_err_nxt   = 1'b1;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_lane  <= w_lane_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_wren  <= i_cpu_wren;
        r_addr  <= i_cpu_addr;
        r_wdata <= i_cpu_wdata;
        r_be    <= i_cpu_be;
      end
    end
  end

  // Memory-side outputs are forced to zero outside the issue cycle.
  always_comb begin
    o_cpu_busy    = (r_state != StIdle);
    o_cpu_rdata   = r_rdata;
    o_cpu_done    = (r_state == StDone);
    o_cpu_err     = (r_state == StDone) && r_err;
    o_mem_request = 1'b0;
    o_mem_wren    = 1'b0;
    o_mem_address = '0;
    o_mem_data    = '0;
    if (r_state == StIssue) begin
      o_mem_request = 1'b1;
      o_mem_wren    = r_wren;
      o_mem_address = r_addr + {{(ADDR_W - LW){1'b0}}, r_lane};
      o_mem_data    = r_wdata[lane_lsb(32'(r_lane)) +: 8];
    end
  end

endmodule
